frame_tx_controller: RTL and testbench

Sequences one camera frame out over the shared UART pixel link. On a start request it freezes frame-buffer writes at the next frame boundary and walks read addresses, in full-resolution or 2x-decimated order. Each pixel is handed to the pixel sender with a start/ready handshake and an enforced inter-pixel gap, and completion is signalled. It sits between the camera frame buffer (read port), the UART pixel sender and the top-level command logic.

---
 rtl/frame_tx_controller_pkg.sv | 17 +
 rtl/frame_tx_controller_if.sv | 26 ++
 rtl/frame_tx_controller_addr_gen.sv | 64 ++++++
 rtl/frame_tx_controller.sv | 143 ++++++++++++++
 tb/tb_frame_tx_controller.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_tx_controller_pkg.sv
// rtl/frame_tx_controller_pkg.sv - shared types and constants for the frame transmit controller
package frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        LOAD,
        FIRE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        FINISH
    } frame_tx_state_t;

    localparam logic [11:0] HEADER_WORD = 12'hFA5;

endpackage

// File: rtl/frame_tx_controller_if.sv
// rtl/frame_tx_controller_if.sv - command, frame-buffer and pixel-sender signals of the frame transmit controller
interface frame_tx_controller_if #(
    parameter int ADDR_W = 17
);
    logic              start;
    logic              small_mode;
    logic              abort;
    logic              frame_end;
    logic              tx_ready;
    logic              tx_start;
    logic [ADDR_W-1:0] address;
    logic              fb_freeze;
    logic              header_sel;
    logic              busy;
    logic              done;

    modport master (
        input  start, small_mode, abort, frame_end, tx_ready,
        output tx_start, address, fb_freeze, header_sel, busy, done
    );

    modport slave (
        output start, small_mode, abort, frame_end, tx_ready,
        input  tx_start, address, fb_freeze, header_sel, busy, done
    );
endinterface

// File: rtl/frame_tx_controller_addr_gen.sv
// rtl/frame_tx_controller_addr_gen.sv - frame-buffer read address walker, full or 2x-decimated order
module frame_tx_addr_gen
    import frame_tx_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic              small_mode,
    output logic [ADDR_W-1:0] address,
    output logic              last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0]     col_q, col_d, col_max;
    logic [RW-1:0]     row_q, row_d, row_max;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              col_end;

    assign col_max = small_mode ? CW'(WIDTH / 2 - 1) : CW'(WIDTH - 1);
    assign row_max = small_mode ? RW'(HEIGHT / 2 - 1) : RW'(HEIGHT - 1);
    assign col_end = (col_q == col_max);
    assign last    = col_end && (row_q == row_max);
    assign address = addr_q;

    // Decimated order skips every other column, and the odd line at row end
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (advance) begin
            if (col_end) begin
                col_d  = '0;
                row_d  = row_q + 1'b1;
                addr_d = addr_q + (small_mode ? ADDR_W'(WIDTH + 2) : ADDR_W'(1));
            end else begin
                col_d  = col_q + 1'b1;
                addr_d = addr_q + (small_mode ? ADDR_W'(2) : ADDR_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/frame_tx_controller.sv
// rtl/frame_tx_controller.sv - sequences one frame out to the UART pixel sender
// Optional sync-word preamble before pixel 0 when FRAME_TX_HEADER_EN is defined.
module frame_tx_controller
    import frame_tx_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int TIME_DELAY = 5000,
    parameter int ADDR_W     = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_tx_controller_if.master bus
);
    localparam int GW = $clog2(TIME_DELAY + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(TIME_DELAY - 1);
`ifdef FRAME_TX_HEADER_EN
    localparam logic HEADER_EN = 1'b1;
`else
    localparam logic HEADER_EN = 1'b0;
`endif

    frame_tx_state_t state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            small_q, small_d;
    logic            tx_start_q, tx_start_d;
    logic            fb_freeze_q, fb_freeze_d;
    logic            header_q, header_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            clear, advance, last;

    frame_tx_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .advance    (advance),
        .small_mode (small_q),
        .address    (bus.address),
        .last       (last)
    );

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        small_d     = small_q;
        fb_freeze_d = fb_freeze_q;
        header_d    = header_q;
        busy_d      = busy_q;
        tx_start_d  = 1'b0;
        done_d      = 1'b0;
        clear       = 1'b0;
        advance     = 1'b0;
        if (bus.abort) begin
            state_d     = IDLE;
            fb_freeze_d = 1'b0;
            header_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    small_d = bus.small_mode;
                    clear   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = WAIT_FRAME;
                end
                WAIT_FRAME: if (bus.frame_end) begin
                    fb_freeze_d = 1'b1;
                    header_d    = HEADER_EN;
                    state_d     = LOAD;
                end
                LOAD: begin
                    tx_start_d = 1'b1;
                    state_d    = FIRE;
                end
                FIRE: state_d = WAIT_BUSY;
                WAIT_BUSY: if (!bus.tx_ready) state_d = WAIT_DONE;
                WAIT_DONE: if (bus.tx_ready) begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
                GAP: begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - 1'b1;
                    end else if (header_q) begin
                        // Header word reuses address 0, so pixel 0 follows without advancing
                        header_d = 1'b0;
                        state_d  = LOAD;
                    end else if (last) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        advance = 1'b1;
                        state_d = LOAD;
                    end
                end
                FINISH: begin
                    fb_freeze_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            small_q     <= 1'b0;
            tx_start_q  <= 1'b0;
            fb_freeze_q <= 1'b0;
            header_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            small_q     <= small_d;
            tx_start_q  <= tx_start_d;
            fb_freeze_q <= fb_freeze_d;
            header_q    <= header_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.fb_freeze = fb_freeze_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef FRAME_TX_HEADER_EN
    assign bus.header_sel = header_q;
`else
    assign bus.header_sel = 1'b0;
`endif

endmodule

// File: tb/tb_frame_tx_controller.sv
// tb/tb_frame_tx_controller.sv - scoreboard bench for frame_tx_controller with a pixel-sender model
module tb_frame_tx_controller;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int TD = 3;
    localparam int AW = 5;
    // Period = 2 + accept(2) + shift(5) + TD(3) with this sender model
    localparam int PERIOD     = 12;
    localparam int RISE2START = 4;
    localparam int DONE_LAT   = 11;

    typedef struct {
        logic [AW-1:0] addr;
        logic          hdr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    frame_tx_controller_if #(.ADDR_W(AW)) bus();

    frame_tx_controller #(
        .WIDTH(W), .HEIGHT(H), .TIME_DELAY(TD), .ADDR_W(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   done_count = 0;
    int   start_count = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int a, input logic h);
        exp_t e;
        e.addr = AW'(a);
        e.hdr  = h;
        exp_q.push_back(e);
    endtask

    task automatic push_header();
`ifdef FRAME_TX_HEADER_EN
        push(0, 1'b1);
`endif
    endtask

    task automatic push_full();
        push_header();
        for (int a = 0; a < W * H; a++) push(a, 1'b0);
    endtask

    task automatic push_small();
        int tbl[8] = '{0, 2, 4, 6, 16, 18, 20, 22};
        push_header();
        for (int i = 0; i < 8; i++) push(tbl[i], 1'b0);
    endtask

    task automatic pulse_start(input logic sm);
        @(negedge clk);
        bus.small_mode = sm;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.small_mode = 1'b0;
    endtask

    task automatic pulse_frame_end();
        @(negedge clk);
        bus.frame_end = 1'b1;
        @(negedge clk);
        bus.frame_end = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done_count > base) return;
        end
        total++;
        bad++;
        $display("FAIL %s: done never seen, required 1 pulse", name);
    endtask

    task automatic wait_starts(input int target, input string name);
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #1;
            if (start_count >= target) return;
        end
        total++;
        bad++;
        $display("FAIL %s: tx_start count %0d, required %0d", name, start_count, target);
    endtask

    task automatic wait_ready(input logic lvl, input string name);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (bus.tx_ready === lvl) return;
        end
        total++;
        bad++;
        $display("FAIL %s: tx_ready stuck, required %0d", name, lvl);
    endtask

    // Pixel sender: ready drops 2 cycles after tx_start and stays low for 5 cycles
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                @(negedge clk);
                @(negedge clk);
                bus.tx_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus.tx_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each tx_start and checks pacing and completion
    initial begin
        logic prev_ready = 1'b1;
        logic have_prev = 1'b0;
        logic after_done = 1'b0;
        int   prev_start = 0;
        int   rise_cyc = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.tx_ready === 1'b1 && prev_ready === 1'b0) rise_cyc = cyc;
            prev_ready = bus.tx_ready;
            if (after_done) begin
                check("idle_busy_after_done", bus.busy, 0);
                check("idle_freeze_after_done", bus.fb_freeze, 0);
                check("done_one_cycle", bus.done, 0);
                after_done = 1'b0;
            end
            if (bus.tx_start === 1'b1) begin
                start_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx_start: got address %0d, required no pulse", bus.address);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel_address", bus.address, e.addr);
                    check("pixel_header_sel", bus.header_sel, e.hdr);
                end
                check("freeze_at_tx_start", bus.fb_freeze, 1);
                if (have_prev) begin
                    check("pixel_period", cyc - prev_start, PERIOD);
                    check("ready_rise_to_start", cyc - rise_cyc, RISE2START);
                end
                have_prev = 1'b1;
                prev_start = cyc;
            end
            if (bus.done === 1'b1) begin
                done_count++;
                check("done_queue_empty", exp_q.size(), 0);
                check("done_latency", cyc - prev_start, DONE_LAT);
                check("freeze_in_finish", bus.fb_freeze, 1);
                after_done = 1'b1;
            end
            if (bus.busy !== 1'b1) have_prev = 1'b0;
        end
    end

    initial begin
        int base;
        bus.start = 1'b0;
        bus.small_mode = 1'b0;
        bus.abort = 1'b0;
        bus.frame_end = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_start", bus.tx_start, 0);
        check("reset_address", bus.address, 0);
        check("reset_fb_freeze", bus.fb_freeze, 0);
        check("reset_header_sel", bus.header_sel, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        pulse_frame_end();
        check("frame_end_idle_busy", bus.busy, 0);
        check("frame_end_idle_freeze", bus.fb_freeze, 0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", bus.busy, 0);

        // Full frame, with a stray start mid-transfer in small mode
        push_full();
        base = done_count;
        pulse_start(1'b0);
        check("busy_after_start", bus.busy, 1);
        check("freeze_in_wait_frame", bus.fb_freeze, 0);
        pulse_frame_end();
        check("freeze_after_frame_end", bus.fb_freeze, 1);
        repeat (20) @(negedge clk);
        pulse_start(1'b1);
        wait_done(base, "full_frame_done");
        repeat (3) @(negedge clk);

        push_small();
        base = done_count;
        pulse_start(1'b1);
        pulse_frame_end();
        wait_done(base, "small_frame_done");
        repeat (3) @(negedge clk);

        // Abort in the third WAIT_DONE
`ifdef FRAME_TX_HEADER_EN
        push(0, 1'b1);
        push(0, 1'b0);
        push(1, 1'b0);
`else
        push(0, 1'b0);
        push(1, 1'b0);
        push(2, 1'b0);
`endif
        base = done_count;
        pulse_start(1'b0);
        pulse_frame_end();
        wait_starts(start_count + 3, "abort_third_pixel");
        wait_ready(1'b0, "abort_wait_done");
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_fb_freeze", bus.fb_freeze, 0);
        check("abort_tx_start", bus.tx_start, 0);
        repeat (30) @(negedge clk);
        check("abort_no_done", done_count, base);
        check("abort_queue_drained", exp_q.size(), 0);

        push_full();
        base = done_count;
        pulse_start(1'b0);
        pulse_frame_end();
        wait_done(base, "restart_frame_done");
        repeat (3) @(negedge clk);

        // Asynchronous reset while in GAP
        push_header();
`ifndef FRAME_TX_HEADER_EN
        push(0, 1'b0);
`endif
        base = done_count;
        pulse_start(1'b0);
        pulse_frame_end();
        wait_starts(start_count + 1, "reset_first_pixel");
        wait_ready(1'b0, "reset_sender_busy");
        wait_ready(1'b1, "reset_in_gap");
        #2;
        rst = 1'b0;
        #1;
        check("async_tx_start", bus.tx_start, 0);
        check("async_address", bus.address, 0);
        check("async_fb_freeze", bus.fb_freeze, 0);
        check("async_header_sel", bus.header_sel, 0);
        check("async_busy", bus.busy, 0);
        check("async_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_no_done", done_count, base);
        check("reset_queue_empty", exp_q.size(), 0);
        check("reset_stays_idle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
